async_sram_ctrl: RTL and testbench

Parametrised asynchronous-mode controller for the board's cellular RAM, replacing the fixed 6-cycle read/write FSM. It accepts single read or write requests over a ready/req handshake and drives the RAM control strobes for a programmable access window. It also provides per-byte write enables, a registered read-data capture with a valid strobe, and a bus-recovery gap between accesses. It sits between the audio/sample sequencing logic and the RAM pins.

---
 rtl/async_sram_ctrl_if.sv | 18 +
 rtl/async_sram_ctrl.sv | 102 ++++++++++
 tb/tb_async_sram_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/async_sram_ctrl_if.sv
// async_sram_ctrl_if: request/response bus between the sample sequencer and the cellular RAM controller.
interface async_sram_ctrl_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] be;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;

    modport master (output req, we, addr, wdata, be, input ready, done, rdata, rdata_valid);
    modport slave  (input req, we, addr, wdata, be, output ready, done, rdata, rdata_valid);
endinterface

// File: rtl/async_sram_ctrl.sv
// async_sram_ctrl: asynchronous-mode cellular RAM controller with programmable access window and bus recovery gap.
module async_sram_ctrl #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 6,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    async_sram_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] MemAdr,
    inout  wire  [DATA_W-1:0] MemDB,
    output logic              RamAdv,
    output logic              RamClk,
    output logic              RamCS,
    output logic              MemOE,
    output logic              MemWR,
    output logic              RamLB,
    output logic              RamUB
);
    localparam int BW = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [BW-1:0]       be_q;
    logic                we_q;
    logic                busy, wait_done, turn_done;

    assign busy      = state_q == READ || state_q == WRITE;
    assign wait_done = cnt_q == 8'(WAIT_CYCLES - 1);
    assign turn_done = cnt_q == 8'(TURN_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.req) begin
                adr_q   <= bus.addr;
                wdata_q <= bus.wdata;
                be_q    <= bus.be;
                we_q    <= bus.we;
            end
            if (state_q == READ && wait_done)
                rdata_q <= MemDB;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req)
                    state_d = bus.we ? WRITE : READ;
            end
            READ, WRITE: begin
                if (wait_done) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                end
            end
            RECOVER: begin
                if (turn_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes come only from registered state so input changes never glitch the RAM pins.
    always_comb begin
        bus.ready       = state_q == IDLE;
        bus.done        = state_q == RECOVER && cnt_q == 8'd0;
        bus.rdata_valid = state_q == RECOVER && cnt_q == 8'd0 && !we_q;
        RamAdv          = !busy;
        RamCS           = !busy;
        MemOE           = state_q != READ;
        MemWR           = state_q != WRITE;
        RamLB           = !(busy && be_q[0]);
        RamUB           = !(busy && be_q[BW-1]);
        RamClk          = 1'b0;
    end

    assign bus.rdata = rdata_q;
    assign MemAdr    = adr_q;
    assign MemDB     = state_q == WRITE ? wdata_q : 'z;
endmodule

// File: tb/tb_async_sram_ctrl.sv
// tb_async_sram_ctrl: randomized accesses against a behavioural RAM and a reference memory image.
module tb_async_sram_ctrl;
    localparam int W = 6;
    localparam int T = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_clr = 1'b1;
    logic [22:0] MemAdr;
    wire  [15:0] MemDB;
    logic        RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
    logic [6:0]  str;
    logic [15:0] ram [16];
    logic [15:0] ref_mem [16];
    logic [15:0] exp_rdata;
    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_acc = 0;

    async_sram_ctrl_if #(.ADDR_W(23), .DATA_W(16)) sif ();

    async_sram_ctrl #(.ADDR_W(23), .DATA_W(16), .WAIT_CYCLES(W), .TURN_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .bus(sif), .MemAdr(MemAdr), .MemDB(MemDB),
        .RamAdv(RamAdv), .RamClk(RamClk), .RamCS(RamCS), .MemOE(MemOE), .MemWR(MemWR),
        .RamLB(RamLB), .RamUB(RamUB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign str = {RamAdv, RamCS, MemOE, MemWR, RamLB, RamUB, RamClk};

    // Behavioural RAM: drives the bus while selected with OE low, latches enabled lanes while WR low.
    assign MemDB = (!RamCS && !MemOE) ? ram[MemAdr[3:0]] : 'z;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (!RamCS && !MemWR) begin
            if (!RamLB) ram[MemAdr[3:0]][7:0]  <= MemDB[7:0];
            if (!RamUB) ram[MemAdr[3:0]][15:8] <= MemDB[15:8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] b);
        return {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
    endfunction

    task automatic access(input bit w, input logic [22:0] a, input logic [15:0] d, input logic [1:0] b, input bit hold);
        for (int n = 0; n < 30 && !sif.ready; n++) @(negedge clk);
        check("ready_pre", sif.ready, 1);
        sif.req = 1'b1; sif.we = w; sif.addr = a; sif.wdata = d; sif.be = b;
        last_acc = cyc;
        if (!w) exp_rdata = ref_mem[a[3:0]];
        for (int i = 1; i <= W + T; i++) begin
            @(negedge clk);
            if (i <= W) begin
                check("strobes", str, {2'b00, w, !w, !b[0], !b[1], 1'b0});
                check("ready_busy", sif.ready, 0);
                check("done_busy", sif.done, 0);
                if (w) check("memdb_wr", MemDB, d);
            end else begin
                check("strobes_rec", str, 7'b1111110);
                check("done", sif.done, i == W + 1);
                check("rvalid", sif.rdata_valid, i == W + 1 && !w);
                if (i == W + 1) check("rdata", sif.rdata, exp_rdata);
            end
            check("adr", MemAdr, a);
            sif.req = hold ? 1'b1 : 1'($urandom_range(0, 1));
            sif.we = 1'($urandom); sif.addr = 23'($urandom);
            sif.wdata = 16'($urandom); sif.be = 2'($urandom);
        end
        @(negedge clk);
        check("ready_post", sif.ready, 1);
        check("strobes_idle", str, 7'b1111110);
        check("adr_hold", MemAdr, a);
        sif.req = 1'b0;
        if (w) ref_mem[a[3:0]] = merge(ref_mem[a[3:0]], d, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0, a1;
        logic [22:0] aa;
        logic [15:0] dd;
        sif.req = 1'b0; sif.we = 1'b0; sif.addr = '0; sif.wdata = '0; sif.be = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        exp_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ram_clr = 1'b0;
        check("rst_ready", sif.ready, 1);
        check("rst_strobes", str, 7'b1111110);
        check("rst_rdata", sif.rdata, 16'h0000);
        check("rst_done", {sif.done, sif.rdata_valid}, 0);
        check("rst_adr", MemAdr, 0);

        access(1, 23'h00005, 16'hA55A, 2'b11, 0);
        access(0, 23'h00005, 16'h0000, 2'b11, 0);
        check("readback", sif.rdata, 16'hA55A);
        access(1, 23'h00005, 16'h12FF, 2'b01, 0);
        access(0, 23'h00005, 16'h0000, 2'b11, 0);
        check("byte_write", sif.rdata, 16'hA5FF);
        access(0, 23'h00005, 16'h0000, 2'b00, 0);
        check("be0_read", sif.rdata, 16'hA5FF);

        access(0, 23'h12345, 16'h0000, 2'b11, 1);
        a0 = last_acc;
        access(0, 23'h00005, 16'h0000, 2'b11, 1);
        a1 = last_acc;
        check("b2b_gap1", 64'(a1 - a0), W + T + 1);
        access(0, 23'h7FFFF5, 16'h0000, 2'b11, 1);
        check("b2b_gap2", 64'(last_acc - a1), W + T + 1);

        for (int n = 0; n < 40; n++)
            access(1'($urandom), 23'($urandom), 16'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0));

        aa = 23'h00009; dd = 16'hBEEF;
        sif.req = 1'b1; sif.we = 1'b1; sif.addr = aa; sif.wdata = dd; sif.be = 2'b11;
        @(negedge clk);
        sif.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_strobes", str, 7'b1111110);
        check("abort_ready", sif.ready, 1);
        check("abort_rdata", sif.rdata, 16'h0000);
        for (int i = 0; i < W + 2; i++) begin
            check("abort_nodone", sif.done, 0);
            @(negedge clk);
        end
        ref_mem[aa[3:0]] = dd;
        exp_rdata = '0;
        access(0, aa, 16'h0000, 2'b11, 0);
        check("abort_readback", sif.rdata, dd);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
